// File: rtl/shift_reg_en_amisha_pkg.sv
// Shared definitions for the shift_reg_en_amisha slice.
//   - direct-mode encodings for ctrl_amisha
//   - burst engine state type
//   - burst direction encodings for dir_amisha
package shift_reg_en_amisha_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_reg_en_amisha_if.sv
// Bus bundle for shift_reg_en_amisha (everything except clock and reset).
//   master : drives enable, mode, load data, serial bits and burst request;
//            observes register contents and burst status.
//   slave  : the register itself (mirror image of master).
interface shift_reg_en_amisha_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             en_amisha;
    logic [1:0]       ctrl_amisha;
    logic [WIDTH-1:0] d_amisha;
    logic             sin_l_amisha;
    logic             sin_r_amisha;
    logic             start_amisha;
    logic             dir_amisha;
    logic [CW-1:0]    cnt_amisha;
    logic [WIDTH-1:0] q_amisha;
    logic             busy_amisha;
    logic             done_amisha;

    modport master (
        output en_amisha, ctrl_amisha, d_amisha, sin_l_amisha, sin_r_amisha,
        output start_amisha, dir_amisha, cnt_amisha,
        input  q_amisha, busy_amisha, done_amisha
    );

    modport slave (
        input  en_amisha, ctrl_amisha, d_amisha, sin_l_amisha, sin_r_amisha,
        input  start_amisha, dir_amisha, cnt_amisha,
        output q_amisha, busy_amisha, done_amisha
    );
endinterface

// File: rtl/shift_reg_en_amisha_burst_ctr.sv
// burst_ctr_amisha: loadable down-counter holding the remaining burst steps.
//   clk_amisha   : clock
//   reset_amisha : synchronous active-low reset (count -> 0)
//   en           : counter advances (load or decrement) only when high
//   load         : with en, capture load_val instead of decrementing
//   load_val     : burst length
//   last         : current count is 1, i.e. this decrement is the final step
module burst_ctr_amisha #(
    parameter int CW = 4
) (
    input  logic          clk_amisha,
    input  logic          reset_amisha,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          last
);
    logic [CW-1:0] remaining;

    always_ff @(posedge clk_amisha) begin
        if (!reset_amisha) begin
            remaining <= '0;
        end else if (en) begin
            if (load) begin
                remaining <= load_val;
            end else if (remaining != '0) begin
                remaining <= remaining - CW'(1);
            end
        end
    end

    assign last = (remaining == CW'(1));
endmodule

// File: rtl/shift_reg_en_amisha.sv
// shift_reg_en_amisha: WIDTH-bit enabled shift register with direct modes
// (hold / shift left / shift right / load) and an autonomous burst engine.
//   clk_amisha   : clock, rising edge
//   reset_amisha : synchronous active-low reset
//   bus (slave)  : en/ctrl/d/sin_l/sin_r/start/dir/cnt in; q/busy/done out
// ROTATE=1 feeds the shifted-out bit back in at the opposite end; ROTATE=0
// takes the serial input for that end instead.
module shift_reg_en_amisha
    import shift_reg_en_amisha_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               ROTATE    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CW        = $clog2(WIDTH + 1)
) (
    input logic                   clk_amisha,
    input logic                   reset_amisha,
    shift_reg_en_amisha_if.slave  bus
);
    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic             dir, dir_nxt;
    logic             busy, busy_nxt;
    logic             done, done_nxt;
    logic             ctr_en, ctr_load, ctr_last;

    function automatic logic [WIDTH-1:0] shl(input logic [WIDTH-1:0] v,
                                             input logic sin);
        logic ins;
        ins = (ROTATE != 0) ? v[WIDTH-1] : sin;
        return {v[WIDTH-2:0], ins};
    endfunction

    function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] v,
                                             input logic sin);
        logic ins;
        ins = (ROTATE != 0) ? v[0] : sin;
        return {ins, v[WIDTH-1:1]};
    endfunction

    burst_ctr_amisha #(.CW(CW)) u_ctr (
        .clk_amisha   (clk_amisha),
        .reset_amisha (reset_amisha),
        .en           (ctr_en),
        .load         (ctr_load),
        .load_val     (bus.cnt_amisha),
        .last         (ctr_last)
    );

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        dir_nxt   = dir;
        busy_nxt  = busy;
        done_nxt  = 1'b0;   // done is a single-cycle pulse, even when stalled
        ctr_en    = 1'b0;
        ctr_load  = 1'b0;
        if (bus.en_amisha) begin
            case (state)
                IDLE: begin
                    // start wins over ctrl; q is left alone on the start edge
                    if (bus.start_amisha) begin
                        if (bus.cnt_amisha == '0) begin
                            done_nxt = 1'b1;
                        end else begin
                            ctr_en    = 1'b1;
                            ctr_load  = 1'b1;
                            dir_nxt   = bus.dir_amisha;
                            busy_nxt  = 1'b1;
                            state_nxt = SHIFT;
                        end
                    end else begin
                        case (bus.ctrl_amisha)
                            MODE_SHL:  q_nxt = shl(q, bus.sin_r_amisha);
                            MODE_SHR:  q_nxt = shr(q, bus.sin_l_amisha);
                            MODE_LOAD: q_nxt = bus.d_amisha;
                            default:   q_nxt = q;
                        endcase
                    end
                end
                SHIFT: begin
                    q_nxt  = (dir == DIR_RIGHT) ? shr(q, bus.sin_l_amisha)
                                                : shl(q, bus.sin_r_amisha);
                    ctr_en = 1'b1;
                    if (ctr_last) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_amisha) begin
        if (!reset_amisha) begin
            state <= IDLE;
            q     <= RESET_VAL;
            dir   <= DIR_LEFT;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            dir   <= dir_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    assign bus.q_amisha    = q;
    assign bus.busy_amisha = busy;
    assign bus.done_amisha = done;
endmodule

// File: tb/tb_shift_reg_en_amisha.sv
// Bench for shift_reg_en_amisha: two instances (ROTATE=0 and ROTATE=1) share
// one stimulus stream; a behavioural model pushes expected outputs into a
// queue each cycle, popped and compared after the edge, plus directed values.
module tb_shift_reg_en_amisha;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    typedef struct {
        logic [W-1:0] q0;
        logic [W-1:0] q1;
        logic         busy;
        logic         done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic          en, start, dir, sin_l, sin_r;
    logic [1:0]    ctrl;
    logic [W-1:0]  d;
    logic [CW-1:0] cnt;

    int n_vec = 0;
    int n_err = 0;
    exp_t sb[$];

    // model state
    logic [W-1:0] m_q0, m_q1;
    logic         m_busy, m_done, m_dir;
    int           m_rem;

    always #5 clk = ~clk;

    shift_reg_en_amisha_if #(.WIDTH(W)) if0 ();
    shift_reg_en_amisha_if #(.WIDTH(W)) if1 ();

    assign if0.en_amisha = en;     assign if1.en_amisha = en;
    assign if0.ctrl_amisha = ctrl; assign if1.ctrl_amisha = ctrl;
    assign if0.d_amisha = d;       assign if1.d_amisha = d;
    assign if0.sin_l_amisha = sin_l; assign if1.sin_l_amisha = sin_l;
    assign if0.sin_r_amisha = sin_r; assign if1.sin_r_amisha = sin_r;
    assign if0.start_amisha = start; assign if1.start_amisha = start;
    assign if0.dir_amisha = dir;   assign if1.dir_amisha = dir;
    assign if0.cnt_amisha = cnt;   assign if1.cnt_amisha = cnt;

    shift_reg_en_amisha #(.WIDTH(W), .ROTATE(0)) dut0 (
        .clk_amisha (clk), .reset_amisha (rst_n), .bus (if0.slave)
    );
    shift_reg_en_amisha #(.WIDTH(W), .ROTATE(1)) dut1 (
        .clk_amisha (clk), .reset_amisha (rst_n), .bus (if1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Arithmetic form of the shifts, independent of the RTL's slicing.
    function automatic logic [W-1:0] m_left(input logic [W-1:0] v, input logic b);
        return W'((v << 1) | W'(b));
    endfunction
    function automatic logic [W-1:0] m_right(input logic [W-1:0] v, input logic b);
        return W'((v >> 1) | (W'(b) << (W - 1)));
    endfunction

    task automatic model_edge();
        logic nd;
        nd = 1'b0;
        if (!rst_n) begin
            m_q0 = '0; m_q1 = '0; m_busy = 1'b0; m_rem = 0; m_dir = 1'b0;
        end else if (en) begin
            if (!m_busy) begin
                if (start) begin
                    if (cnt == 0) nd = 1'b1;
                    else begin m_rem = int'(cnt); m_dir = dir; m_busy = 1'b1; end
                end else if (ctrl == 2'b01) begin
                    m_q0 = m_left(m_q0, sin_r);  m_q1 = m_left(m_q1, m_q1[W-1]);
                end else if (ctrl == 2'b10) begin
                    m_q0 = m_right(m_q0, sin_l); m_q1 = m_right(m_q1, m_q1[0]);
                end else if (ctrl == 2'b11) begin
                    m_q0 = d; m_q1 = d;
                end
            end else begin
                if (m_dir) begin
                    m_q0 = m_right(m_q0, sin_l); m_q1 = m_right(m_q1, m_q1[0]);
                end else begin
                    m_q0 = m_left(m_q0, sin_r);  m_q1 = m_left(m_q1, m_q1[W-1]);
                end
                m_rem--;
                if (m_rem == 0) begin m_busy = 1'b0; nd = 1'b1; end
            end
        end
        m_done = rst_n ? nd : 1'b0;
    endtask

    // One clock: push the model's prediction, clock, then pop and compare.
    task automatic step();
        exp_t e;
        model_edge();
        e.q0 = m_q0; e.q1 = m_q1; e.busy = m_busy; e.done = m_done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("q_rot0", 32'(if0.q_amisha), 32'(e.q0));
        chk("q_rot1", 32'(if1.q_amisha), 32'(e.q1));
        chk("busy",   32'(if1.busy_amisha), 32'(e.busy));
        chk("done",   32'(if1.done_amisha), 32'(e.done));
        chk("busy0",  32'(if0.busy_amisha), 32'(e.busy));
        chk("done0",  32'(if0.done_amisha), 32'(e.done));
        chk("excl",   32'(if1.busy_amisha & if1.done_amisha), 32'd0);
    endtask

    task automatic idle_in();
        en = 1'b1; start = 1'b0; ctrl = 2'b00; dir = 1'b0;
        sin_l = 1'b0; sin_r = 1'b0; cnt = '0; d = '0;
    endtask

    task automatic load(input logic [W-1:0] v);
        idle_in(); ctrl = 2'b11; d = v; step(); ctrl = 2'b00;
    endtask

    initial begin
        idle_in();
        m_q0 = '0; m_q1 = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_dir = 1'b0;

        // reset overrides load and start
        rst_n = 1'b0; ctrl = 2'b11; d = 8'hA5; start = 1'b1; cnt = 4'd3;
        step(); step();
        chk("rst_q",    32'(if0.q_amisha), 32'h00);
        chk("rst_busy", 32'(if0.busy_amisha), 32'd0);
        chk("rst_done", 32'(if0.done_amisha), 32'd0);
        rst_n = 1'b1;

        // load, then enable gating
        load(8'hA5);
        chk("load", 32'(if0.q_amisha), 32'hA5);
        en = 1'b0; ctrl = 2'b11; d = 8'hFF;
        repeat (3) step();
        chk("en_hold", 32'(if0.q_amisha), 32'hA5);

        // serial shifts
        idle_in(); ctrl = 2'b01; sin_r = 1'b1; step();
        chk("shl_ser", 32'(if0.q_amisha), 32'h4B);
        load(8'hA5);
        ctrl = 2'b10; sin_l = 1'b0; step();
        chk("shr_ser", 32'(if0.q_amisha), 32'h52);
        chk("shr_rot", 32'(if1.q_amisha), 32'hD2);

        // burst rotate left by 3, ctrl=load held during burst
        load(8'h81);
        start = 1'b1; dir = 1'b0; cnt = 4'd3; step();
        chk("bst_start_q", 32'(if1.q_amisha), 32'h81);
        start = 1'b0; ctrl = 2'b11; d = 8'hFF;
        step(); chk("bst_s1", 32'(if1.q_amisha), 32'h03);
        step(); chk("bst_s2", 32'(if1.q_amisha), 32'h06);
        ctrl = 2'b00;
        step(); chk("bst_s3", 32'(if1.q_amisha), 32'h0C);
        chk("bst_done", 32'(if1.done_amisha), 32'd1);
        step(); chk("bst_done_clr", 32'(if1.done_amisha), 32'd0);

        // same burst with a 2-cycle stall after the first shift
        load(8'h81);
        start = 1'b1; cnt = 4'd3; step();
        start = 1'b0; step();
        en = 1'b0; step(); step();
        chk("stall_q", 32'(if1.q_amisha), 32'h03);
        chk("stall_busy", 32'(if1.busy_amisha), 32'd1);
        en = 1'b1; step(); step();
        chk("stall_q_end", 32'(if1.q_amisha), 32'h0C);
        chk("stall_done", 32'(if1.done_amisha), 32'd1);
        step();

        // zero-length burst
        start = 1'b1; cnt = 4'd0; step();
        start = 1'b0;
        chk("zero_done", 32'(if1.done_amisha), 32'd1);
        chk("zero_busy", 32'(if1.busy_amisha), 32'd0);
        chk("zero_q",    32'(if1.q_amisha), 32'h0C);
        step();

        // burst longer than WIDTH, right, serial fill with ones
        load(8'h81);
        start = 1'b1; dir = 1'b1; cnt = 4'd10; sin_l = 1'b1; step();
        start = 1'b0;
        repeat (10) step();
        chk("long_fill", 32'(if0.q_amisha), 32'hFF);
        chk("long_rot",  32'(if1.q_amisha), 32'h60);
        step();

        // reset in the middle of a burst
        load(8'h81);
        start = 1'b1; dir = 1'b0; cnt = 4'd5; step();
        start = 1'b0; step(); step();
        rst_n = 1'b0; step();
        chk("mid_rst_q",    32'(if1.q_amisha), 32'h00);
        chk("mid_rst_busy", 32'(if1.busy_amisha), 32'd0);
        rst_n = 1'b1;
        repeat (4) begin
            step();
            chk("mid_rst_nodone", 32'(if1.done_amisha), 32'd0);
        end

        // random traffic against the model
        for (int i = 0; i < 150; i++) begin
            rst_n = ($urandom_range(0, 40) != 0);
            en    = ($urandom_range(0, 4) != 0);
            start = ($urandom_range(0, 5) == 0);
            ctrl  = 2'($urandom_range(0, 3));
            d     = W'($urandom);
            dir   = 1'($urandom_range(0, 1));
            sin_l = 1'($urandom_range(0, 1));
            sin_r = 1'($urandom_range(0, 1));
            cnt   = CW'($urandom_range(0, 12));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/shift_reg_en_amisha.md
Name: shift_reg_en_amisha

Overview:
Parametrised successor to the single-bit enabled D flip-flop. A WIDTH-bit register with a global enable and four direct modes: hold, shift left, shift right and parallel load. Rotate or serial-fill is selected by parameter. An autonomous burst engine shifts the register a programmed number of positions and reports busy/done. It is the general storage/serialiser primitive for later datapath blocks.

Parameters:
WIDTH, 8, register width in bits (>=2)
ROTATE, 0, 1 = shifted-out bit re-enters at the opposite end; 0 = serial input bit enters
RESET_VAL, 0, value of q_amisha after reset (WIDTH bits)
CW, $clog2(WIDTH+1), burst count width (derived; do not override)

Ports:
clk_amisha  input  1  clock; all state updates on its rising edge
reset_amisha  input  1  synchronous, active-low reset
en_amisha  input  1  global enable; 0 freezes register, counter and state
ctrl_amisha  input  2  direct mode: 00 hold, 01 shift left, 10 shift right, 11 load
d_amisha  input  WIDTH  parallel load data
sin_l_amisha  input  1  serial bit entering at MSB on right shift (ROTATE=0)
sin_r_amisha  input  1  serial bit entering at LSB on left shift (ROTATE=0)
start_amisha  input  1  begin burst (sampled only in IDLE with en=1)
dir_amisha  input  1  burst direction: 0 left, 1 right
cnt_amisha  input  CW  burst length in shift steps
q_amisha  output  WIDTH  register contents
busy_amisha  output  1  burst in progress
done_amisha  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset: reset_amisha=0 at a rising edge sets q=RESET_VAL, busy=0, done=0, remaining=0, state=IDLE. Reset overrides en, start and ctrl. Reset mid-burst aborts the burst with no done pulse.
- Shift left: q <= {q[W-2:0], ins}. ins = sin_r_amisha, or q[W-1] when ROTATE=1.
- Shift right: q <= {ins, q[W-1:1]}. ins = sin_l_amisha, or q[0] when ROTATE=1.
- done_amisha is high for exactly one cycle. It clears on the next edge regardless of en.
- en_amisha=0: q, remaining and state hold. start and ctrl are ignored.
- States: IDLE, SHIFT.
- IDLE, en=1, start=0: apply ctrl_amisha per mode table, one step per edge.
- IDLE, en=1, start=1: start has priority over ctrl; q is not modified on this edge.
  - cnt=0: done pulses next cycle, stay IDLE, busy stays 0.
  - cnt>0: remaining<=cnt, latch dir, busy<=1, go to SHIFT.
- SHIFT, en=1: shift once in the latched direction, remaining--. ctrl, start, d, cnt and dir are ignored.
  - When remaining=1 on that edge: go to IDLE, busy<=0, done<=1.
- Latency: start sampled at edge k → shifts on edges k+1..k+cnt (plus any stall cycles) → done high in the cycle after the final shift.
- cnt may exceed WIDTH; exactly cnt steps are performed.
  - ROTATE=0: register fully refilled with serial input bits.
  - ROTATE=1: net rotation is cnt mod WIDTH.
- busy_amisha and done_amisha are never high together.

Decomposition:
- Shared package: mode constants MODE_HOLD/MODE_SHL/MODE_SHR/MODE_LOAD, state enum {IDLE, SHIFT}, DIR_LEFT/DIR_RIGHT constants.
- One sub-module: burst_ctr_amisha.
  - Loadable CW-bit down-counter with enable, synchronous active-low reset, and last-step flag.
  - Instantiated once; the shift datapath stays in the top module.

Test Plan:
- Reset: WIDTH=8; reset_amisha=0, en=1, ctrl=11, d=8'hA5, start=1 for 2 edges → q=8'h00, busy=0, done=0.
- Load and enable gating:
  - ctrl=11, d=8'hA5, en=1 → q=8'hA5.
  - Then en=0, ctrl=11, d=8'hFF for 3 edges → q stays 8'hA5.
- Serial shifts, ROTATE=0, q=8'hA5:
  - ctrl=01, sin_r=1 → q=8'h4B.
  - Reload 8'hA5; ctrl=10, sin_l=0 → q=8'h52.
- Burst rotate, ROTATE=1, q=8'h81, start=1, dir=0, cnt=3:
  - busy high for 3 cycles; q steps 03, 06, 0C.
  - done pulses 1 cycle after the final shift; ctrl=11 asserted during the burst is ignored.
- Stall and zero count:
  - Same burst with en=0 for 2 cycles after the first shift → q holds 8'h03 while stalled; done arrives 2 cycles later; final q=8'h0C.
  - start with cnt=0 → done pulse next cycle, busy never asserted, q unchanged.
- Reset mid-burst: start cnt=5, assert reset_amisha=0 after 2 shifts → next edge q=8'h00, busy=0, no done pulse afterwards.
